// File: rtl/receptor_16_uc_pkg.sv
// receptor_16_uc_pkg
// Shared definitions for the 16-bit receive control unit: the 4-bit state
// encodings (also read by the debug 7-segment decoder), the FSM state type
// and a helper that tells whether a state belongs to an active reception.
package receptor_16_uc_pkg;

  localparam logic [3:0] EST_INICIAL      = 4'd0;
  localparam logic [3:0] EST_ESPERA_HIGH  = 4'd1;
  localparam logic [3:0] EST_CARREGA_HIGH = 4'd2;
  localparam logic [3:0] EST_ESPERA_LOW   = 4'd3;
  localparam logic [3:0] EST_CARREGA_LOW  = 4'd4;
  localparam logic [3:0] EST_FIM          = 4'd5;
  localparam logic [3:0] EST_ERRO         = 4'd6;

  typedef enum logic [3:0] {
    INICIAL      = EST_INICIAL,
    ESPERA_HIGH  = EST_ESPERA_HIGH,
    CARREGA_HIGH = EST_CARREGA_HIGH,
    ESPERA_LOW   = EST_ESPERA_LOW,
    CARREGA_LOW  = EST_CARREGA_LOW,
    FIM          = EST_FIM,
    ERRO         = EST_ERRO
  } estado_t;

  // A word is "in flight" everywhere except idle, done and error.
  function automatic logic is_recebendo(input estado_t e);
    logic r;
    case (e)
      INICIAL, FIM, ERRO: r = 1'b0;
      ESPERA_HIGH, CARREGA_HIGH, ESPERA_LOW, CARREGA_LOW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/receptor_16_uc_contador_m.sv
// contador_m
// Modulo-M up counter used as the inter-byte timeout timer.
// Ports:
//   clock_i  - system clock
//   reset_i  - asynchronous active-high reset, clears the count
//   clear_i  - synchronous clear (has priority over enable_i)
//   enable_i - count one step this cycle
//   tc_o     - terminal count: count is M-1
module contador_m #(
  parameter int M = 10_000,
  parameter int W = $clog2(M)
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear wins, otherwise wrap at M-1
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      if (count_q == ULTIMO) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == ULTIMO);

endmodule

// File: rtl/receptor_16_uc.sv
// receptor_16_uc
// Control unit for the 16-bit serial receive datapath. Arms on iniciar,
// loads the first good byte as bits [15:8] and the second as bits [7:0],
// then pulses pronto. Parity failure on either byte, or no second byte
// within TIMEOUT_CYCLES, aborts the word with a sticky error flag.
// Ports:
//   clock, reset (async, active-high)
//   iniciar                 - arm from INICIAL or ERRO (level)
//   fim_receber, parity_ok  - byte-complete pulse and its parity result
//   load_data_high/low      - 1-cycle load strobes to the datapath
//   recebendo               - word in progress
//   pronto                  - 1-cycle word-complete pulse
//   erro_paridade/timeout   - sticky error flags, cleared on re-arm
//   db_estado               - current state code for debug displays
// All outputs are registers loaded from the next-state value, so they
// follow the state register exactly with no input-to-output paths.
module receptor_16_uc
  import receptor_16_uc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fim_receber,
  input  logic       parity_ok,
  output logic       load_data_high,
  output logic       load_data_low,
  output logic       recebendo,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_timeout,
  output logic [3:0] db_estado
);

  estado_t    estado_q;
  estado_t    estado_d;
  logic       erro_paridade_q;
  logic       erro_paridade_d;
  logic       erro_timeout_q;
  logic       erro_timeout_d;
  logic       load_high_q;
  logic       load_low_q;
  logic       recebendo_q;
  logic       pronto_q;
  logic [3:0] db_estado_q;
  logic       timeout_tc_s;

  // The timer restarts while the high byte is loaded and runs only in
  // ESPERA_LOW, so ERRO is reached TIMEOUT_CYCLES after entering it.
  contador_m #(
    .M (TIMEOUT_CYCLES),
    .W (CNT_W)
  ) u_timeout (
    .clock_i  (clock),
    .reset_i  (reset),
    .clear_i  (estado_q == CARREGA_HIGH),
    .enable_i (estado_q == ESPERA_LOW),
    .tc_o     (timeout_tc_s)
  );

  // next-state and error-flag logic
  always_comb begin
    estado_d        = estado_q;
    erro_paridade_d = erro_paridade_q;
    erro_timeout_d  = erro_timeout_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_d = ESPERA_HIGH;
        end else begin
          estado_d = INICIAL;
        end
      end
      ESPERA_HIGH: begin
        if (fim_receber && parity_ok) begin
          estado_d = CARREGA_HIGH;
        end else if (fim_receber) begin
          estado_d        = ERRO;
          erro_paridade_d = 1'b1;
        end else begin
          estado_d = ESPERA_HIGH;
        end
      end
      CARREGA_HIGH: estado_d = ESPERA_LOW;
      ESPERA_LOW: begin
        // a byte arriving on the terminal-count cycle beats the timeout
        if (fim_receber && parity_ok) begin
          estado_d = CARREGA_LOW;
        end else if (fim_receber) begin
          estado_d        = ERRO;
          erro_paridade_d = 1'b1;
        end else if (timeout_tc_s) begin
          estado_d       = ERRO;
          erro_timeout_d = 1'b1;
        end else begin
          estado_d = ESPERA_LOW;
        end
      end
      CARREGA_LOW: estado_d = FIM;
      FIM:         estado_d = INICIAL;
      ERRO: begin
        if (iniciar) begin
          estado_d        = ESPERA_HIGH;
          erro_paridade_d = 1'b0;
          erro_timeout_d  = 1'b0;
        end else begin
          estado_d = ERRO;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // state, flag and decoded-output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q        <= INICIAL;
      erro_paridade_q <= 1'b0;
      erro_timeout_q  <= 1'b0;
      load_high_q     <= 1'b0;
      load_low_q      <= 1'b0;
      recebendo_q     <= 1'b0;
      pronto_q        <= 1'b0;
      db_estado_q     <= 4'd0;
    end else begin
      estado_q        <= estado_d;
      erro_paridade_q <= erro_paridade_d;
      erro_timeout_q  <= erro_timeout_d;
      load_high_q     <= (estado_d == CARREGA_HIGH);
      load_low_q      <= (estado_d == CARREGA_LOW);
      recebendo_q     <= is_recebendo(estado_d);
      pronto_q        <= (estado_d == FIM);
      db_estado_q     <= estado_d;
    end
  end

  assign load_data_high = load_high_q;
  assign load_data_low  = load_low_q;
  assign recebendo      = recebendo_q;
  assign pronto         = pronto_q;
  assign erro_paridade  = erro_paridade_q;
  assign erro_timeout   = erro_timeout_q;
  assign db_estado      = db_estado_q;

endmodule

// File: tb/tb_receptor_16_uc.sv
// Self-checking bench for receptor_16_uc with TIMEOUT_CYCLES = 20.
// A small stand-in for the datapath register is kept here so the word
// assembled by the load strobes can be checked at pronto.
module tb_receptor_16_uc;

  localparam int T = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       fim_receber;
  logic       parity_ok;
  logic       load_data_high;
  logic       load_data_low;
  logic       recebendo;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_timeout;
  logic [3:0] db_estado;

  logic [7:0]  rx_byte;
  logic [15:0] data_q;
  logic [9:0]  outs_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  receptor_16_uc #(.TIMEOUT_CYCLES(T)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .fim_receber    (fim_receber),
    .parity_ok      (parity_ok),
    .load_data_high (load_data_high),
    .load_data_low  (load_data_low),
    .recebendo      (recebendo),
    .pronto         (pronto),
    .erro_paridade  (erro_paridade),
    .erro_timeout   (erro_timeout),
    .db_estado      (db_estado)
  );

  // datapath register stand-in: loads the held byte on each strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= 16'h0000;
    end else begin
      if (load_data_high) data_q[15:8] <= rx_byte;
      if (load_data_low)  data_q[7:0]  <= rx_byte;
    end
  end

  assign outs_s = {db_estado, load_data_high, load_data_low, recebendo,
                   pronto, erro_paridade, erro_timeout};

  function automatic logic [9:0] ex(input logic [3:0] db, input logic ldh,
                                    input logic ldl, input logic rec,
                                    input logic pr, input logic ep,
                                    input logic et);
    return {db, ldh, ldl, rec, pr, ep, et};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // one clock: drive inputs, let the edge happen, settle 1 time unit
  task automatic step(input logic ini, input logic fi, input logic pa,
                      input logic [7:0] b);
    iniciar     = ini;
    fim_receber = fi;
    parity_ok   = pa;
    if (fi) rx_byte = b;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    iniciar     = 1'b0;
    fim_receber = 1'b0;
    parity_ok   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // reset, arm, take one good high byte, land in ESPERA_LOW
  task automatic to_espera_low(input string tag, input logic [7:0] b);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, b);
    check({tag, " carrega_high"}, outs_s, ex(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check({tag, " espera_low"}, outs_s, ex(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  typedef struct {
    logic        ini;
    logic        fim;
    logic        par;
    logic [7:0]  byt;
    int          rep;
    logic [9:0]  exp;
    logic        chk;
    logic [15:0] wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ini, input logic fim,
                              input logic par, input logic [7:0] byt,
                              input int rep, input logic [9:0] e,
                              input logic chk, input logic [15:0] wd);
    vec_t v;
    v.ini = ini; v.fim = fim; v.par = par; v.byt = byt;
    v.rep = rep; v.exp = e; v.chk = chk; v.wd = wd;
    return v;
  endfunction

  // behavioural reference: phase of the word plus one-cycle events
  int         m_phase;   // 0 idle, 1 waiting high, 2 waiting low, 3 error
  logic       m_ldh, m_ldl, m_done, m_ep, m_et;
  int         m_wait;
  logic [7:0] m_hi, m_lo;

  function automatic logic [3:0] m_db();
    if (m_ldh)  return 4'd2;
    if (m_ldl)  return 4'd4;
    if (m_done) return 4'd5;
    case (m_phase)
      1:       return 4'd1;
      2:       return 4'd3;
      3:       return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  initial begin
    logic [9:0] e0;
    int  n_pronto;
    logic saw_bad;
    logic [15:0] words[2];
    logic [7:0]  seq_bytes[4];
    int  send_at[4];
    logic prev_fim;
    int  div;

    rx_byte = 8'h00;
    do_reset();
    check("reset_state", outs_s, 10'd0);
    check("reset_data", data_q, 16'h0000);

    // ---- table: normal word, then parity errors on high and low byte
    e0 = ex(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vq.push_back(mk(1, 0, 0, 8'h00, 1, ex(4'd1, 0, 0, 1, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 1, 1, 8'hA5, 1, ex(4'd2, 1, 0, 1, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 0, 0, 8'h00, 9, e0, 0, 16'h0));
    vq.push_back(mk(0, 1, 1, 8'h5A, 1, ex(4'd4, 0, 1, 1, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, ex(4'd5, 0, 0, 0, 1, 0, 0), 1, 16'hA55A));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, ex(4'd0, 0, 0, 0, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 1, 1, 8'h11, 1, ex(4'd0, 0, 0, 0, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(1, 0, 0, 8'h00, 1, ex(4'd1, 0, 0, 1, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 1, 0, 8'hFF, 1, ex(4'd6, 0, 0, 0, 0, 1, 0), 0, 16'h0));
    vq.push_back(mk(0, 0, 0, 8'h00, 3, ex(4'd6, 0, 0, 0, 0, 1, 0), 0, 16'h0));
    vq.push_back(mk(0, 1, 1, 8'h33, 1, ex(4'd6, 0, 0, 0, 0, 1, 0), 0, 16'h0));
    vq.push_back(mk(1, 0, 0, 8'h00, 1, ex(4'd1, 0, 0, 1, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 1, 1, 8'h12, 1, ex(4'd2, 1, 0, 1, 0, 0, 0), 0, 16'h0));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, e0, 0, 16'h0));
    vq.push_back(mk(0, 1, 0, 8'h34, 1, ex(4'd6, 0, 0, 0, 0, 1, 0), 0, 16'h0));
    vq.push_back(mk(1, 0, 0, 8'h00, 1, ex(4'd1, 0, 0, 1, 0, 0, 0), 0, 16'h0));

    foreach (vq[i]) begin
      for (int r = 0; r < vq[i].rep; r++) begin
        step(vq[i].ini, vq[i].fim, vq[i].par, vq[i].byt);
        check($sformatf("vec%0d.%0d", i, r), outs_s, vq[i].exp);
        if (vq[i].chk) check($sformatf("vec%0d_data", i), data_q, vq[i].wd);
      end
    end

    // ---- timeout: ERRO exactly T cycles after entering ESPERA_LOW
    to_espera_low("tmo", 8'hC3);
    saw_bad = 1'b0;
    for (int k = 1; k < T; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      if (db_estado != 4'd3 || load_data_low || pronto) saw_bad = 1'b1;
    end
    check("tmo_still_waiting", {31'd0, saw_bad}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("tmo_erro", outs_s, ex(4'd6, 0, 0, 0, 0, 0, 1));
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("tmo_held", outs_s, ex(4'd6, 0, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("tmo_rearm", outs_s, ex(4'd1, 0, 0, 1, 0, 0, 0));

    // ---- boundary: low byte on the terminal-count cycle wins
    to_espera_low("tc", 8'hBE);
    for (int k = 1; k < T; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hEF);
    check("tc_carrega_low", outs_s, ex(4'd4, 0, 1, 1, 0, 0, 0));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("tc_pronto", outs_s, ex(4'd5, 0, 0, 0, 1, 0, 0));
    check("tc_data", data_q, 16'hBEEF);

    // ---- reset mid-word: asynchronous, then a lone byte is ignored
    to_espera_low("rst", 8'h77);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_outs", outs_s, 10'd0);
    check("rst_async_data", data_q, 16'h0000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1, 8'h99);
    check("rst_lone_byte", outs_s, 10'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_idle", outs_s, 10'd0);

    // ---- continuous iniciar: two back-to-back words
    do_reset();
    seq_bytes[0] = 8'h12; seq_bytes[1] = 8'h34;
    seq_bytes[2] = 8'h56; seq_bytes[3] = 8'h78;
    send_at[0] = 3; send_at[1] = 7; send_at[2] = 11; send_at[3] = 15;
    n_pronto = 0;
    words[0] = 16'h0; words[1] = 16'h0;
    for (int c = 1; c <= 25; c++) begin
      logic f;
      logic [7:0] b;
      f = 1'b0;
      b = 8'h00;
      for (int j = 0; j < 4; j++) begin
        if (send_at[j] == c) begin
          f = 1'b1;
          b = seq_bytes[j];
        end
      end
      step(1'b1, f, 1'b1, b);
      if (pronto) begin
        if (n_pronto < 2) words[n_pronto] = data_q;
        n_pronto++;
      end
    end
    check("cont_pronto_count", n_pronto, 32'd2);
    check("cont_word0", words[0], 16'h1234);
    check("cont_word1", words[1], 16'h5678);

    // ---- randomized run against the reference model
    do_reset();
    m_phase = 0; m_ldh = 0; m_ldl = 0; m_done = 0;
    m_ep = 0; m_et = 0; m_wait = 0; m_hi = 8'h00; m_lo = 8'h00;
    prev_fim = 1'b0;
    div = 4;
    for (int c = 0; c < 3000; c++) begin
      logic ini, fi, pa;
      logic [7:0] b;
      if (c % 150 == 0) div = ($urandom_range(0, 1) == 0) ? 4 : 60;
      ini = ($urandom_range(0, 3) == 0);
      fi  = ($urandom_range(0, div - 1) == 0) && !prev_fim;
      pa  = ($urandom_range(0, 7) != 0);
      b   = 8'($urandom);
      prev_fim = fi;

      if (m_ldh) begin
        m_ldh = 0; m_phase = 2; m_wait = 0;
      end else if (m_ldl) begin
        m_ldl = 0; m_done = 1;
      end else if (m_done) begin
        m_done = 0; m_phase = 0;
      end else begin
        case (m_phase)
          0: if (ini) m_phase = 1;
          1: if (fi) begin
               if (pa) begin m_ldh = 1; m_hi = b; end
               else begin m_phase = 3; m_ep = 1; end
             end
          2: if (fi) begin
               if (pa) begin m_ldl = 1; m_lo = b; end
               else begin m_phase = 3; m_ep = 1; end
             end else if (m_wait == T - 1) begin
               m_phase = 3; m_et = 1;
             end else begin
               m_wait++;
             end
          3: if (ini) begin m_phase = 1; m_ep = 0; m_et = 0; end
          default: m_phase = 0;
        endcase
      end

      step(ini, fi, pa, b);
      check($sformatf("rnd%0d", c), outs_s,
            ex(m_db(), m_ldh, m_ldl,
               m_ldh | m_ldl | (!m_done && (m_phase == 1 || m_phase == 2)),
               m_done, m_ep, m_et));
      if (m_done) check($sformatf("rnd%0d_data", c), data_q, {m_hi, m_lo});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
